// File: rtl/mchan_iir_avg.sv
// mchan_iir_avg: time-multiplexed per-channel first-order IIR averager.
// Define MCHAN_IIR_ROUND_EN for round-half-up, saturating o_data.
module mchan_iir_avg #(
  parameter int IW = 16,
  parameter int OW = 16,
  parameter int NCHAN = 8,
  parameter int MAXLG = 8,
  parameter int LGNCHAN = $clog2(NCHAN),
  parameter int LW = $clog2(MAXLG + 1),
  parameter int AW = ((IW > OW) ? IW : OW) + MAXLG,
  parameter logic [AW-1:0] RESET_VALUE = '0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_clear,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [LGNCHAN-1:0] i_chan,
  input  logic [LW-1:0]      i_lgalpha,
  input  logic [IW-1:0]      i_data,
  output logic               o_valid,
  output logic [LGNCHAN-1:0] o_chan,
  output logic [OW-1:0]      o_data
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [LGNCHAN-1:0] LAST = LGNCHAN'(NCHAN - 1);
  localparam logic [LW-1:0] LGMAX = LW'(MAXLG);

  state_t state;
  logic [LGNCHAN-1:0] idx;
  logic [AW-1:0] mem [NCHAN];

  logic v1, v2, v3;
  logic [LGNCHAN-1:0] c1, c2, c3;
  logic [LW-1:0] l1, l2;
  logic [AW-1:0] x1, x2;
  logic [AW-1:0] rd, fv, yb, y3, a3, ynew;
  logic f1;
  logic signed [AW:0] diff, adj;
  logic take, wr;
  logic [OW-1:0] res;

  assign take = i_valid && o_ready && !i_clear;
  assign wr = v3 && !i_clear && i_reset_n;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= CLEAR;
      idx <= '0;
      o_ready <= 1'b0;
    end else begin
      o_ready <= (state == RUN) && !i_clear;
      if (i_clear) begin
        state <= CLEAR;
        idx <= '0;
      end else if (state == CLEAR) begin
        idx <= idx + 1'b1;
        if (idx == LAST) state <= RUN;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= take;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge i_clk) begin
    c1 <= i_chan;
    l1 <= (i_lgalpha > LGMAX) ? LGMAX : i_lgalpha;
    x1 <= {i_data, {(AW-IW){1'b0}}};
    c2 <= c1;
    l2 <= l1;
    x2 <= x1;
    f1 <= v3 && (c3 == c1);
    fv <= ynew;
    c3 <= c2;
    y3 <= yb;
    a3 <= AW'(adj);
  end

  always_ff @(posedge i_clk) begin
    if (state == CLEAR) mem[idx] <= RESET_VALUE;
    else if (wr) mem[c3] <= ynew;
    rd <= mem[c1];
  end

  // Newest copy wins: the op one stage ahead, then the one two ahead.
  always_comb begin
    yb = rd;
    if (v3 && (c3 == c2)) yb = ynew;
    else if (f1) yb = fv;
  end

  assign diff = $signed({x2[AW-1], x2}) - $signed({yb[AW-1], yb});
  assign adj = diff >>> l2;
  assign ynew = y3 + a3;

`ifdef MCHAN_IIR_ROUND_EN
  logic [OW-1:0] top;
  logic rb;
  assign top = ynew[AW-1:AW-OW];
  assign rb = ynew[AW-OW-1];
  assign res = (rb && top == {1'b0, {(OW-1){1'b1}}}) ? top : top + OW'(rb);
`else
  assign res = ynew[AW-1:AW-OW];
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_chan <= '0;
      o_data <= '0;
    end else begin
      o_valid <= wr;
      if (wr) begin
        o_chan <= c3;
        o_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_mchan_iir_avg.sv
// tb_mchan_iir_avg: random + directed stimulus against an integer model.
// Model keeps each channel's average as a plain longint.
module tb_mchan_iir_avg;

  localparam int NCHAN = 8;
  localparam int MAXLG = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, clear, valid, ready, o_valid;
  logic [2:0] chan, o_chan;
  logic [3:0] lgalpha;
  logic [15:0] data, o_data;

  mchan_iir_avg dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .i_clear(clear),
    .i_valid(valid),
    .o_ready(ready),
    .i_chan(chan),
    .i_lgalpha(lgalpha),
    .i_data(data),
    .o_valid(o_valid),
    .o_chan(o_chan),
    .o_data(o_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int due;
    int ch;
    int dat;
  } exp_t;

  exp_t q[$];
  longint acc[NCHAN];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", tag, got, want, cyc);
    end
  endtask

  function automatic int model(int ch, int lg, int d);
    longint x, y;
    int l;
    l = (lg > MAXLG) ? MAXLG : lg;
    x = longint'(d) * 256;
    acc[ch] = acc[ch] + ((x - acc[ch]) >>> l);
    y = acc[ch] >>> 8;
`ifdef MCHAN_IIR_ROUND_EN
    y = y + ((acc[ch] >>> 7) & 1);
    if (y > 32767) y = 32767;
`endif
    return int'(y) & 32'hFFFF;
  endfunction

  task automatic check_out();
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("valid", {31'b0, o_valid}, 32'd1);
      chk("chan", {29'b0, o_chan}, q[0].ch);
      chk("data", {16'b0, o_data}, q[0].dat);
      void'(q.pop_front());
    end else begin
      chk("idle", {31'b0, o_valid}, 32'd0);
    end
  endtask

  task automatic tick(input bit v, input int ch, input int lg,
                      input int d, input bit clr);
    exp_t e;
    @(negedge clk);
    check_out();
    valid = v;
    chan = ch[2:0];
    lgalpha = lg[3:0];
    data = d[15:0];
    clear = clr;
    if (clr) begin
      q.delete();
      foreach (acc[i]) acc[i] = 0;
    end else if (v && ready) begin
      e.due = cyc + 4;
      e.ch = ch;
      e.dat = model(ch, lg, d);
      q.push_back(e);
    end
  endtask

  int cnt;
  int last;

  initial begin
    reset_n = 1'b0;
    clear = 1'b0;
    valid = 1'b0;
    chan = '0;
    lgalpha = '0;
    data = '0;
    foreach (acc[i]) acc[i] = 0;
    repeat (3) tick(0, 0, 0, 0, 0);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_chan", {29'b0, o_chan}, 32'd0);
    chk("rst_data", {16'b0, o_data}, 32'd0);
    reset_n = 1'b1;
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      tick(0, 0, 0, 0, 0);
      if (ready) break;
      cnt++;
    end
    chk("rst_rdy_lo", cnt, NCHAN + 1);

    for (int c = 0; c < NCHAN; c++) tick(1, c, MAXLG, 0, 0);
    repeat (3) tick(1, 0, 1, 16'h4000, 0);
    tick(1, 0, 0, 16'h4000, 0);
    tick(1, 1, 0, -16'sh4000, 0);
    tick(1, 0, 2, 0, 0);
    tick(1, 1, 2, 0, 0);
    tick(1, 0, 3, 123, 0);
    tick(1, 1, 3, 456, 0);
    tick(0, 0, 0, 0, 1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick(0, 0, 0, 0, 0);
      if (ready) break;
      cnt++;
    end
    chk("clr_rdy_lo", cnt, NCHAN + 1);
    tick(1, 0, 8, 0, 0);
    tick(1, 3, 15, 16'h1234, 0);
    tick(1, 3, 15, 16'h1234, 0);
    tick(1, 4, 8, 16'h1234, 0);
    tick(1, 4, 8, 16'h1234, 0);
    tick(1, 5, 1, 3, 0);
    repeat (40) tick(1, 2, 1, 16'h7FFF, 0);
    tick(1, 6, 0, -32768, 0);

    last = 0;
    for (int k = 0; k < 600; k++) begin
      int ch;
      ch = ($urandom_range(0, 2) == 0) ? last : int'($urandom_range(0, 7));
      last = ch;
      tick($urandom_range(0, 9) < 8, ch, $urandom_range(0, 15),
           int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 199) == 0);
    end
    repeat (6) tick(0, 0, 0, 0, 0);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
